// File: rtl/aes128_stream_adapter.sv
// aes128_stream_adapter
//   Word-serial wrapper around a combinational AES-128 encryption core.
//   - Collects 4 key words and then 4 plaintext words (MSW first) from a 32-bit valid/ready stream.
//   - Holds them on the core inputs and waits SETTLE_CYCLES.
//   - Captures the cipher text and replays it as 4 words on a 32-bit valid/ready stream.
//   Optional feature macro: AES_KEY_HOLD_EN
//   - Adds s_new_key.
//   - Lets a block reuse the previously loaded key and send only its 4 plaintext words.
module aes128_stream_adapter #(
   parameter int SETTLE_CYCLES = 4   // 1..255, must cover the core's combinational delay
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
`ifdef AES_KEY_HOLD_EN
   input  logic         s_new_key,
`endif
   output logic         m_valid,
   input  logic         m_ready,
   output logic [31:0]  m_data,
   output logic         m_last,
   output logic         busy,
   output logic [127:0] core_key,
   output logic [127:0] core_plain_text,
   input  logic [127:0] core_cipher_text
);

   typedef enum logic [1:0] {LOAD_KEY, LOAD_PT, WAIT, SEND} state_t;

   localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] word_cnt_q, word_cnt_d;
   logic [7:0] settle_q, settle_d;

   // Index 0 of each array is the most significant word ([127:96]).
   logic [0:3][31:0] key_reg, pt_reg, ct_reg;

   logic key_we, pt_we, ct_we, skip_key;

`ifdef AES_KEY_HOLD_EN
   logic key_valid_q, key_valid_set;
`endif

   assign core_key        = key_reg;
   assign core_plain_text = pt_reg;
   assign busy            = (state_q != LOAD_KEY) || (word_cnt_q != 2'd0);

   // A block may skip its key words only when a key is already held and the
   // sender did not request a new one with word0.
`ifdef AES_KEY_HOLD_EN
   assign skip_key = key_valid_q && !s_new_key && (word_cnt_q == 2'd0);
`else
   assign skip_key = 1'b0;
`endif

   // State register and word/settle counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= LOAD_KEY;
         word_cnt_q <= 2'd0;
         settle_q   <= 8'd0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         settle_q   <= settle_d;
      end
   end

   // Next-state logic, handshake outputs and register write enables
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      settle_d   = settle_q;
      key_we     = 1'b0;
      pt_we      = 1'b0;
      ct_we      = 1'b0;
      s_ready    = 1'b0;
      m_valid    = 1'b0;
      m_data     = 32'd0;
      m_last     = 1'b0;
`ifdef AES_KEY_HOLD_EN
      key_valid_set = 1'b0;
`endif
      case (state_q)
         LOAD_KEY: begin
            s_ready = 1'b1;
            if (s_valid) begin
               if (skip_key) begin
                  // word0 of this block is already plaintext word0
                  pt_we      = 1'b1;
                  word_cnt_d = 2'd1;
                  state_d    = LOAD_PT;
               end else begin
                  key_we     = 1'b1;
                  word_cnt_d = word_cnt_q + 2'd1;
                  if (word_cnt_q == 2'd3) begin
                     state_d = LOAD_PT;
`ifdef AES_KEY_HOLD_EN
                     key_valid_set = 1'b1;
`endif
                  end
               end
            end
         end
         LOAD_PT: begin
            s_ready = 1'b1;
            if (s_valid) begin
               pt_we      = 1'b1;
               word_cnt_d = word_cnt_q + 2'd1;
               if (word_cnt_q == 2'd3) begin
                  state_d  = WAIT;
                  settle_d = SETTLE_INIT;
               end
            end
         end
         WAIT: begin
            if (settle_q == 8'd0) begin
               ct_we      = 1'b1;
               word_cnt_d = 2'd0;
               state_d    = SEND;
            end else begin
               settle_d = settle_q - 8'd1;
            end
         end
         SEND: begin
            m_valid = 1'b1;
            m_data  = ct_reg[word_cnt_q];
            m_last  = (word_cnt_q == 2'd3);
            if (m_ready) begin
               word_cnt_d = word_cnt_q + 2'd1;
               if (word_cnt_q == 2'd3) state_d = LOAD_KEY;
            end
         end
         default: state_d = LOAD_KEY;
      endcase
   end

   // Key/plaintext/cipher registers; key and plaintext move only on input transfers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_reg <= '0;
         pt_reg  <= '0;
         ct_reg  <= '0;
      end else begin
         if (key_we) key_reg[word_cnt_q] <= s_data;
         if (pt_we)  pt_reg[word_cnt_q]  <= s_data;
         if (ct_we)  ct_reg              <= core_cipher_text;
      end
   end

`ifdef AES_KEY_HOLD_EN
   // Remembers that a complete key has been loaded since reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                key_valid_q <= 1'b0;
      else if (key_valid_set) key_valid_q <= 1'b1;
   end
`endif

endmodule
